// File: rtl/serial_arith_pkg.sv
// Shared state encoding for the sequential adder/subtractor family.
package serial_arith_pkg;

  // Encoding 2'd3 is unused; every FSM in the family treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  always_comb begin
    w_axb = a ^ b;
    d     = w_axb ^ bin;
    bout  = (~a & b) | (~w_axb & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit
// per clock, using a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_ra, r_rb;
  // Upper WIDTH-1 result bits; the oldest bit falls out of the shift anyway.
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_br, r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_d, w_br_n;
  logic             w_idle, w_load, w_last;
  logic [WIDTH-1:0] w_acc_sh;

  full_subtractor u_cell (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_n)
  );

  // Decode state: 2'd3 behaves exactly like IDLE.
  always_comb begin
    w_idle   = (r_state != ST_SHIFT) && (r_state != ST_DONE);
    w_load   = w_idle && start;
    w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST);
    w_acc_sh = {w_d, r_acc};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = start ? ST_SHIFT : ST_IDLE;
    endcase
  end

  // Operand shifting, accumulation and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_acc  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_ra  <= a;
      r_rb  <= b;
      r_br  <= bin;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_ra  <= r_ra >> 1;
      r_rb  <= r_rb >> 1;
      r_acc <= w_acc_sh[WIDTH-1:1];
      r_br  <= w_br_n;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_acc_sh;
        r_bout <= w_br_n;
      end
    end
  end

  assign busy = !w_idle;
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=4: directed cases, exhaustive sweep
// and randomized ops, checked every cycle against a countdown-based model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  // Model: cycles left until the op completes; result published as done rises.
  int           m_left = 0;
  logic [W-1:0] m_diff = '0, m_pd = '0;
  logic         m_bout = 1'b0, m_pb = 1'b0;
  bit           chk_en = 1'b0;
  int           n_pass = 0, n_tot = 0;
  int           busy_cycles = 0, done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_diff = '0;
      m_bout = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = W + 1;
        m_pd   = W'(int'(a) - int'(b) - int'(bin));
        m_pb   = (int'(a) < int'(b) + int'(bin));
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_diff = m_pd;
        m_bout = m_pb;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, plus activity counters.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 8'(busy), 8'(m_left > 0));
      check("done", 8'(done), 8'(m_left == 1));
      check("diff", 8'(diff), 8'(m_diff));
      check("bout", 8'(bout), 8'(m_bout));
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_cnt++;
    end
  end

  // Hold start until accepted, then scramble inputs and wait for done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, output int lat);
    int k;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (m_left != W + 1 && k < 20);
    check("accept_wait", 8'(k < 20), 8'd1);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    check("done_wait", 8'(lat < 20), 8'd1);
    #1;
  endtask

  initial begin
    int lat, k;
    logic [8:0] v;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_diff", 8'(diff), 8'd0);
    rst = 1'b0;

    // 5 - 3
    busy_cycles = 0;
    run_op(4'b0101, 4'b0011, 1'b0, lat);
    check("t1_latency", 8'(lat), 8'd5);
    check("t1_diff", 8'(diff), 8'b0010);
    check("t1_bout", 8'(bout), 8'd0);
    repeat (2) @(negedge clk);
    #1 check("t1_busy_cycles", 8'(busy_cycles), 8'd5);

    run_op(4'b0011, 4'b0101, 1'b0, lat);
    check("t2_diff", 8'(diff), 8'b1110);
    check("t2_bout", 8'(bout), 8'd1);
    run_op(4'b0000, 4'b0000, 1'b1, lat);
    check("t3_diff", 8'(diff), 8'b1111);
    check("t3_bout", 8'(bout), 8'd1);
    run_op(4'b1111, 4'b1111, 1'b0, lat);
    check("t4_diff", 8'(diff), 8'b0000);
    check("t4_bout", 8'(bout), 8'd0);

    // Start while busy is ignored.
    repeat (2) @(negedge clk);
    done_cnt = 0;
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b0000; b = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("ign_done_cnt", 8'(done_cnt), 8'd1);
    check("ign_diff", 8'(diff), 8'b0111);
    check("ign_bout", 8'(bout), 8'd0);

    // Reset mid-operation discards the op.
    a = 4'b0110; b = 4'b0010; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    #1;
    check("mrst_busy", 8'(busy), 8'd0);
    check("mrst_done", 8'(done), 8'd0);
    check("mrst_diff", 8'(diff), 8'd0);
    check("mrst_bout", 8'(bout), 8'd0);
    repeat (8) @(negedge clk);
    #1 check("mrst_no_done", 8'(done_cnt), 8'd0);
    run_op(4'b1001, 4'b0100, 1'b0, lat);
    check("mrst_next_diff", 8'(diff), 8'b0101);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      run_op(v[8:5], v[4:1], v[0], lat);
    end

    // Randomized ops with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      repeat (k) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), lat);
    end

    repeat (4) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
